byte_serializer: RTL and testbench
==================================

# byte_serializer

Upstream feeder for the bit-serial deserializer in `top`. The block accepts one parallel byte through a valid/ready handshake and waits until the deserializer reports ready on its `status` output. It then shifts the byte out LSB-first on a `data_in`/`write_in`-style strobe pair. This replaces the hand-driven bit stimulus, so the deserializer→queue path can be driven by real RTL.

## Interface
- `DATA_WIDTH`, default 8: byte width; the bit counter is `$clog2(DATA_WIDTH)` wide.
- `WRITE_CYCLES`, default 10: clocks `write_out` is held high per bit; legal values ≥1.
- `GAP_CYCLES`, default 10: clocks `write_out` is held low after each bit; legal values ≥1.
- `START_DELAY`, default 10: clocks from sampling `status_in`=1 to the first strobe; legal values ≥0.
- `clock`  in  1: single clock; all state changes on its rising edge.
- `reset`  in  1: **synchronous, active-low** reset.
- `data_in`  in  DATA_WIDTH: parallel byte to send.
- `valid_in`  in  1: `data_in` is valid.
- `ready_out`  out  1: block can accept a byte; transfer occurs on an edge with `valid_in`&`ready_out`.
- `status_in`  in  1: deserializer `status_out`; 1 = ready to receive a byte.
- `serial_out`  out  1: current bit, connects to the deserializer `data_in`.
- `write_out`  out  1: bit strobe, connects to the deserializer `write_in`.
- `busy_out`  out  1: 1 whenever the block is not in IDLE.

## Operation
- FSM states: IDLE, WAIT_STATUS, DELAY, DRIVE, GAP.
- **IDLE**
  - `ready_out`=1, `busy_out`=0.
  - On `valid_in`=1, capture `data_in` into a shift register, clear the bit counter, go to WAIT_STATUS.
- **WAIT_STATUS**
  - Hold the byte indefinitely while `status_in`=0.
  - On `status_in`=1, go to DELAY if `START_DELAY`>0, otherwise go to DRIVE.
- **DELAY**
  - Count `START_DELAY` cycles, then go to DRIVE.
  - `status_in` is ignored here; the transfer is committed.
- **DRIVE**
  - `write_out`=1 and `serial_out`=shift[0] for `WRITE_CYCLES` cycles, then go to GAP.
- **GAP**
  - `write_out`=0 and `serial_out` holds the same bit for `GAP_CYCLES` cycles.
  - If this was bit `DATA_WIDTH`-1, go to IDLE.
  - Otherwise shift right, increment the bit counter, go to DRIVE.
- Bit order is LSB first; bit k is driven during the k-th DRIVE/GAP pair.
- `status_in` is ignored from DELAY until the return to IDLE; a deassertion mid-byte does not abort.
- `data_in` changes after capture have no effect.
- Outputs are registered: `serial_out`, `write_out`, `busy_out`. `ready_out` is decoded from the state register (IDLE).
- Cycle counter is sized for max(`WRITE_CYCLES`,`GAP_CYCLES`,`START_DELAY`). It reloads on every state entry and never wraps within a state.

## Timing
- Reset values: state IDLE, `ready_out`=1, `busy_out`=0, `write_out`=0, `serial_out`=0, counters 0, shift register 0.
- Reset asserted mid-byte: at the next edge all of the above apply, the byte is discarded, and `write_out` falls at that edge.
- Accept at edge E0 means the state is WAIT_STATUS from E0.
- If `status_in`=1 is sampled at E1:
  - with `START_DELAY`=0, `write_out` rises at E1;
  - otherwise `write_out` rises at E1+`START_DELAY`.
- Each bit occupies exactly `WRITE_CYCLES`+`GAP_CYCLES` cycles. `serial_out` changes only on the edge where `write_out` rises.
- Last GAP ends at edge Ef = first strobe edge + `DATA_WIDTH`·(`WRITE_CYCLES`+`GAP_CYCLES`). `ready_out`=1 from Ef.
- `valid_in` is high throughout:
  - no acceptance during a transfer;
  - the next byte is accepted at Ef+1;
  - there is a minimum of one IDLE cycle between bytes.
- No combinational path from inputs to outputs.

## Test plan
- **Reset:** hold `reset`=0 for 3 edges with `valid_in`=1 → all outputs at their reset values, no byte captured. Release → `ready_out`=1.
- **Defaults (10/10/10), byte 8'b10011001, `status_in` rising 5 cycles after accept:**
  - 8 `write_out` pulses of 10 cycles, each followed by a 10-cycle gap;
  - `serial_out` sequence 1,0,0,1,1,0,0,1;
  - first strobe 10 cycles after `status_in` is sampled high;
  - the deserializer in `top` produces data_out=8'h99 and len_out=1.
- **Params (1/1/0), bytes 8'hA5 then 8'h3C back-to-back, `status_in` held 1:**
  - first strobe one cycle after accept;
  - bits 1,0,1,0,0,1,0,1 then 0,0,1,1,1,1,0,0;
  - 16 cycles per byte;
  - second byte accepted one cycle after `ready_out` rises.
- **`status_in` low for 50 cycles after accept** → no strobe and `busy_out`=1 throughout; transfer starts per the latency rule once `status_in`=1.
- **`status_in` dropped to 0 during bit 3** → transfer still completes all 8 bits unchanged.
- **Reset asserted during bit 4's DRIVE** → `write_out`=0 and `ready_out`=1 at the next edge. A new byte 8'h0F after release is sent in full, with no leftover bits.

Source files
------------

// File: rtl/byte_serializer.sv
// byte_serializer: takes one parallel word over valid/ready, waits for the downstream
// deserializer to report ready, then shifts the word out LSB-first on a data/strobe pair.
module byte_serializer #(
    parameter int DATA_WIDTH   = 8,
    parameter int WRITE_CYCLES = 10,
    parameter int GAP_CYCLES   = 10,
    parameter int START_DELAY  = 10
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    output logic                  ready_out,
    input  logic                  status_in,
    output logic                  serial_out,
    output logic                  write_out,
    output logic                  busy_out
);
    // state       | meaning
    // S_IDLE      | ready for a new word
    // S_WAIT_STAT | word held, waiting for status_in
    // S_DELAY     | committed, counting START_DELAY
    // S_DRIVE     | strobe high, current bit on serial_out
    // S_GAP       | strobe low, bit held
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_STAT = 3'd1,
        S_DELAY     = 3'd2,
        S_DRIVE     = 3'd3,
        S_GAP       = 3'd4
    } state_t;

    localparam int MAX_WG  = (WRITE_CYCLES > GAP_CYCLES) ? WRITE_CYCLES : GAP_CYCLES;
    localparam int MAX_CYC = (MAX_WG > START_DELAY) ? MAX_WG : START_DELAY;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int BIT_W   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    // Counters hold N-1 on entry and the state ends on the edge that sees zero.
    localparam logic [CNT_W-1:0] WRITE_LOAD = CNT_W'(WRITE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LOAD = CNT_W'((START_DELAY > 0) ? START_DELAY - 1 : 0);
    localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(DATA_WIDTH - 1);

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [BIT_W-1:0]      r_bit;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_serial;
    logic                  r_write;
    logic                  r_busy;
    logic [DATA_WIDTH-1:0] w_next_shift;

    assign w_next_shift = r_shift >> 1;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
            r_serial <= 1'b0;
            r_write  <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (valid_in) begin
                        r_shift <= data_in;
                        r_bit   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_WAIT_STAT;
                    end
                end
                S_WAIT_STAT: begin
                    if (status_in) begin
                        if (START_DELAY > 0) begin
                            r_cnt   <= DELAY_LOAD;
                            r_state <= S_DELAY;
                        end else begin
                            r_cnt    <= WRITE_LOAD;
                            r_write  <= 1'b1;
                            r_serial <= r_shift[0];
                            r_state  <= S_DRIVE;
                        end
                    end
                end
                S_DELAY: begin
                    if (r_cnt == '0) begin
                        r_cnt    <= WRITE_LOAD;
                        r_write  <= 1'b1;
                        r_serial <= r_shift[0];
                        r_state  <= S_DRIVE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_DRIVE: begin
                    if (r_cnt == '0) begin
                        r_cnt   <= GAP_LOAD;
                        r_write <= 1'b0;
                        r_state <= S_GAP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_GAP: begin
                    if (r_cnt == '0) begin
                        if (r_bit == LAST_BIT) begin
                            r_cnt   <= '0;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            // serial_out only moves on the edge the strobe rises
                            r_shift  <= w_next_shift;
                            r_serial <= w_next_shift[0];
                            r_bit    <= r_bit + 1'b1;
                            r_cnt    <= WRITE_LOAD;
                            r_write  <= 1'b1;
                            r_state  <= S_DRIVE;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_write <= 1'b0;
                end
            endcase
        end
    end

    assign ready_out  = (r_state == S_IDLE);
    assign serial_out = r_serial;
    assign write_out  = r_write;
    assign busy_out   = r_busy;

endmodule

// File: tb/tb_byte_serializer.sv
// Bench for byte_serializer: instance 0 uses default timing (10/10/10), instance 1 uses 1/1/0.
module tb_byte_serializer;
    logic       clock = 1'b0;
    logic [1:0] reset_v  = 2'b00;
    logic [1:0] valid_v  = 2'b00;
    logic [1:0] status_v = 2'b00;
    logic [7:0] data_v [2];
    logic [1:0] ready_v, serial_v, write_v, busy_v;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    byte_serializer #(.DATA_WIDTH(8), .WRITE_CYCLES(10), .GAP_CYCLES(10), .START_DELAY(10)) u_dflt (
        .clock(clock), .reset(reset_v[0]), .data_in(data_v[0]), .valid_in(valid_v[0]),
        .ready_out(ready_v[0]), .status_in(status_v[0]), .serial_out(serial_v[0]),
        .write_out(write_v[0]), .busy_out(busy_v[0]));

    byte_serializer #(.DATA_WIDTH(8), .WRITE_CYCLES(1), .GAP_CYCLES(1), .START_DELAY(0)) u_fast (
        .clock(clock), .reset(reset_v[1]), .data_in(data_v[1]), .valid_in(valid_v[1]),
        .ready_out(ready_v[1]), .status_in(status_v[1]), .serial_out(serial_v[1]),
        .write_out(write_v[1]), .busy_out(busy_v[1]));

    function automatic int wcyc(input int w); return (w == 1) ? 1 : 10; endfunction
    function automatic int gcyc(input int w); return (w == 1) ? 1 : 10; endfunction
    function automatic int dcyc(input int w); return (w == 1) ? 0 : 10; endfunction

    // Drives one word through instance w and checks every cycle against the timing rules:
    // status sampled high at edge E1, first strobe at E1+D, bit k on [k*P, k*P+W) after it.
    // drop_j / rst_j (cycle index after E1, -1 = never) inject a status drop or a reset.
    task automatic run(input int w, input logic [7:0] b, input int lag, input bit keep_valid,
                       input int drop_j, input int rst_j, input string name);
        int W, G, D, P, last, k;
        logic [2:0] exp_rbw, got_rbw;
        logic exp_s;
        W = wcyc(w); G = gcyc(w); D = dcyc(w); P = W + G;
        last = D + 8 * P;
        data_v[w]  = b;
        valid_v[w] = 1'b1;
        if (lag > 1) status_v[w] = 1'b0;
        for (int m = 0; m < lag; m++) begin
            @(negedge clock);
            if (m == 0 && !keep_valid) begin
                valid_v[w] = 1'b0;
                data_v[w]  = 8'($urandom);
            end
            got_rbw = {ready_v[w], busy_v[w], write_v[w]};
            checks++;
            if (got_rbw !== 3'b010) begin
                errors++;
                $display("FAIL %s wait inst=%0d m=%0d ready/busy/write got %b want 010", name, w, m, got_rbw);
            end
            if (m == lag - 1) status_v[w] = 1'b1;
        end
        for (int j = 0; j <= last; j++) begin
            @(negedge clock);
            if (j < D)          exp_rbw = 3'b010;
            else if (j == last) exp_rbw = 3'b100;
            else                exp_rbw = {2'b01, ((j - D) % P) < W};
            got_rbw = {ready_v[w], busy_v[w], write_v[w]};
            checks++;
            if (got_rbw !== exp_rbw) begin
                errors++;
                $display("FAIL %s strobe inst=%0d j=%0d ready/busy/write got %b want %b", name, w, j, got_rbw, exp_rbw);
            end
            if (j >= D) begin
                k = (j - D) / P;
                if (k > 7) k = 7;
                exp_s = b[k];
                checks++;
                if (serial_v[w] !== exp_s) begin
                    errors++;
                    $display("FAIL %s serial inst=%0d j=%0d bit=%0d got %b want %b", name, w, j, k, serial_v[w], exp_s);
                end
            end
            if (j == drop_j) status_v[w] = 1'b0;
            if (j == rst_j) begin
                reset_v[w] = 1'b0;
                @(negedge clock);
                checks++;
                if ({ready_v[w], busy_v[w], write_v[w], serial_v[w]} !== 4'b1000) begin
                    errors++;
                    $display("FAIL %s abort inst=%0d ready/busy/write/serial got %b want 1000", name, w,
                             {ready_v[w], busy_v[w], write_v[w], serial_v[w]});
                end
                reset_v[w] = 1'b1;
                valid_v[w] = 1'b0;
                return;
            end
        end
    endtask

    task automatic test_reset();
        reset_v  = 2'b00;
        valid_v  = 2'b11;
        status_v = 2'b11;
        data_v[0] = 8'hFF;
        data_v[1] = 8'hFF;
        for (int e = 0; e < 3; e++) begin
            @(negedge clock);
            for (int w = 0; w < 2; w++) begin
                checks++;
                if ({ready_v[w], busy_v[w], write_v[w], serial_v[w]} !== 4'b1000) begin
                    errors++;
                    $display("FAIL reset inst=%0d edge=%0d ready/busy/write/serial got %b want 1000", w, e,
                             {ready_v[w], busy_v[w], write_v[w], serial_v[w]});
                end
            end
        end
        reset_v  = 2'b11;
        valid_v  = 2'b00;
        status_v = 2'b00;
        @(negedge clock);
        for (int w = 0; w < 2; w++) begin
            checks++;
            if ({ready_v[w], busy_v[w]} !== 2'b10) begin
                errors++;
                $display("FAIL reset_release inst=%0d ready/busy got %b want 10", w, {ready_v[w], busy_v[w]});
            end
        end
    endtask

    task automatic test_defaults();
        run(0, 8'b1001_1001, 5, 1'b0, -1, -1, "defaults");
    endtask

    task automatic test_back_to_back();
        run(1, 8'hA5, 1, 1'b1, -1, -1, "b2b_first");
        run(1, 8'h3C, 1, 1'b0, -1, -1, "b2b_second");
    endtask

    task automatic test_status_hold();
        run(0, 8'h6E, 50, 1'b0, -1, -1, "status_hold");
    endtask

    task automatic test_status_drop();
        run(0, 8'hB4, 2, 1'b0, 10 + 3 * 20 + 5, -1, "status_drop");
    endtask

    task automatic test_mid_reset();
        run(0, 8'hF0, 1, 1'b0, -1, 10 + 4 * 20 + 3, "mid_reset");
        run(0, 8'h0F, 3, 1'b0, -1, -1, "after_reset");
    endtask

    task automatic test_random();
        bit keep;
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < 8; i++) begin
                keep = (i < 7) ? 1'($urandom_range(0, 1)) : 1'b0;
                run(w, 8'($urandom), int'($urandom_range(1, 6)), keep, -1, -1, "random");
            end
        end
    endtask

    initial begin
        data_v[0] = 8'h00;
        data_v[1] = 8'h00;
        test_reset();
        test_defaults();
        test_back_to_back();
        test_status_hold();
        test_status_drop();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
